bist_scan_ctrl: RTL and testbench
=================================

BIST_SCAN_CTRL -- requirements
Module: bist_scan_ctrl

Interface
REQ-001 SHALL have parameter CHAIN_LEN, default 12: scan-chain length of the attached circuit under test (CUT), range 2..64.
REQ-002 SHALL have parameter PATTERN_CNT, default 64: patterns per session, range 1..1024.
REQ-003 SHALL have parameter LFSR_SEED, default 16'hACE1: pattern-generator seed, nonzero.
REQ-004 SHALL have parameter GOLDEN_SIG, default 16'h0000: expected final signature.
REQ-005 SHALL have port clock  in  1  rising-edge clock.
REQ-006 SHALL have port reset  in  1  reset, synchronous, active-high.
REQ-007 SHALL have port start  in  1  one-cycle session request.
REQ-008 SHALL have ports busy/done/pass  out  1 each  session active / session complete / signature == GOLDEN_SIG.
REQ-009 SHALL have port signature  out  16  final compacted signature.
REQ-010 SHALL have ports cut_rst/scan_en/scan_in  out  1 each  CUT reset / CUT scan enable / CUT serial data.
REQ-011 SHALL have ports cut_s/cut_dv/cut_l_in  out  1 each, and cut_test_in  out  2, driving the CUT primary inputs.
REQ-012 SHALL have port scan_out  in  1  CUT serial response.
REQ-013 SHALL have ports cut_fz_L/cut_lclk  in  1 each, cut_read_a  in  5, cut_test_out  in  2: CUT primary outputs.

Function
REQ-014 SHALL implement states IDLE, RST_CUT, SHIFT, CAPTURE, UNLOAD, DONE.
REQ-015 IDLE/DONE: start=1 -> RST_CUT; start ignored in every other state.
REQ-016 RST_CUT: one cycle, cut_rst=1, PRPG loaded with LFSR_SEED, MISR cleared to 0, pattern counter cleared -> SHIFT.
REQ-017 SHIFT: exactly CHAIN_LEN cycles with scan_en=1 -> CAPTURE.
REQ-018 CAPTURE: one cycle with scan_en=0; pattern counter increments; -> SHIFT if count < PATTERN_CNT, else -> UNLOAD.
REQ-019 UNLOAD: CHAIN_LEN cycles, scan_en=1, scan_in=0 -> DONE.
REQ-020 PRPG: 16-bit Fibonacci LFSR, polynomial x^16+x^14+x^13+x^11+1, advances once per SHIFT and CAPTURE cycle, holds otherwise.
REQ-021 scan_in = PRPG bit 0 in SHIFT; cut_s, cut_dv, cut_l_in, cut_test_in[1:0] = PRPG bits 5..1 in every state except IDLE/DONE/RST_CUT, where they are 0.
REQ-022 MISR: 16-bit, same polynomial; each compaction cycle: MISR <= lfsr_step(MISR) XOR {6'b0, in_vec[9:0]}.
REQ-023 Compaction cycles: every SHIFT and UNLOAD cycle with in_vec = {9'b0, scan_out}.
REQ-024 busy=1 in RST_CUT..UNLOAD; done=1 only in DONE; signature/pass update on entry to DONE and hold until next RST_CUT.
REQ-025 Latency: start sampled at edge E -> done=1 after edge E+1+PATTERN_CNT*(CHAIN_LEN+1)+CHAIN_LEN (defaults: E+845).
REQ-026 start coincident with reset: reset wins, start dropped.

Reset
REQ-027 Reset SHALL force IDLE and drive busy, done, pass, cut_rst, scan_en, scan_in, all cut_* outputs to 0, signature to 0, PRPG to LFSR_SEED, MISR and counters to 0.
REQ-028 Reset mid-session SHALL abort immediately; no partial signature SHALL be exposed.

Configuration
REQ-029 Macro BIST_PO_COMPACT_EN defined: CAPTURE cycles also compact, in_vec = {cut_fz_L, cut_lclk, cut_read_a, cut_test_out, scan_out}.
REQ-030 Macro undefined: CAPTURE does not touch MISR; GOLDEN_SIG SHALL be regenerated per configuration.

Structure
REQ-031 Package bist_pkg SHALL hold the state enum, polynomial tap constant, LFSR/MISR width (16) and PI/PO vector widths.
REQ-032 Sub-module bist_lfsr16 (step function with parallel XOR input, load, enable) SHALL be instantiated twice: PRPG (input 0) and MISR.

Verification
REQ-033 Reset during SHIFT (pattern 3) -> next cycle busy=0, scan_en=0, signature=0; new start completes normally.
REQ-034 CHAIN_LEN=4, PATTERN_CNT=2, start at edge E -> scan_en high 4 cycles, low 1, high 4, low 1, high 4; done at E+15.
REQ-035 CUT model with stuck-at-0 scan_out -> signature equals reference-model value; pass=0 vs golden of fault-free CUT.
REQ-036 Fault-free CUT, defaults, GOLDEN_SIG from reference model -> pass=1, done held until next start.
REQ-037 start pulsed while busy -> ignored, cycle count unchanged; start in DONE -> new session, done drops next cycle.
REQ-038 With and without BIST_PO_COMPACT_EN, toggling cut_lclk only in CAPTURE changes signature only when macro defined.

Source files
------------

// File: rtl/bist_pkg.sv
// bist_pkg: shared types, widths and LFSR step function for the scan BIST controller
package bist_pkg;

    localparam int LFSR_W = 16;
    localparam int PI_W   = 5;
    localparam int PO_W   = 10;

    // Feedback taps for x^16+x^14+x^13+x^11+1 (bits 15, 13, 12, 10)
    localparam logic [LFSR_W-1:0] POLY_TAPS = 16'hB400;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RST_CUT = 3'd1,
        SHIFT   = 3'd2,
        CAPTURE = 3'd3,
        UNLOAD  = 3'd4,
        DONE    = 3'd5
    } state_e;

    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
        return {s[LFSR_W-2:0], ^(s & POLY_TAPS)};
    endfunction

endpackage

// File: rtl/bist_lfsr16.sv
// bist_lfsr16: 16-bit Fibonacci LFSR with parallel XOR input, used as PRPG and MISR
module bist_lfsr16
    import bist_pkg::*;
#(
    parameter logic [LFSR_W-1:0] RESET_VAL = '0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load_i,
    input  logic              en_i,
    input  logic [LFSR_W-1:0] seed_i,
    input  logic [LFSR_W-1:0] in_i,
    output logic [LFSR_W-1:0] state_o
);

    logic [LFSR_W-1:0] state_q, state_d;

    // Load wins over stepping; the register holds when neither is requested
    always_comb state_d = load_i ? seed_i : en_i ? lfsr_step(state_q) ^ in_i : state_q;

    // State register
    always_ff @(posedge clock) state_q <= reset ? RESET_VAL : state_d;

    assign state_o = state_q;

endmodule

// File: rtl/bist_scan_ctrl.sv
// bist_scan_ctrl: scan BIST session controller with PRPG stimulus and MISR compaction
// Define BIST_PO_COMPACT_EN to also compact CUT primary outputs during CAPTURE.
module bist_scan_ctrl
    import bist_pkg::*;
#(
    parameter int                CHAIN_LEN   = 12,
    parameter int                PATTERN_CNT = 64,
    parameter logic [LFSR_W-1:0] LFSR_SEED   = 16'hACE1,
    parameter logic [LFSR_W-1:0] GOLDEN_SIG  = 16'h0000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [LFSR_W-1:0] signature,
    output logic              cut_rst,
    output logic              scan_en,
    output logic              scan_in,
    output logic              cut_s,
    output logic              cut_dv,
    output logic              cut_l_in,
    output logic [1:0]        cut_test_in,
    input  logic              scan_out,
    input  logic              cut_fz_L,
    input  logic              cut_lclk,
    input  logic [4:0]        cut_read_a,
    input  logic [1:0]        cut_test_out
);

    localparam int CW = $clog2(CHAIN_LEN);
    localparam int PW = $clog2(PATTERN_CNT + 1);

    state_e            state_q, state_d;
    logic [CW-1:0]     bit_cnt_q, bit_cnt_d;
    logic [PW-1:0]     pat_cnt_q, pat_cnt_d;
    logic [LFSR_W-1:0] prpg, misr, misr_in;
    logic [PO_W-1:0]   po_vec;
    logic              last_bit, last_pat, prpg_en, misr_en, sig_vis;

    assign last_bit = bit_cnt_q == CW'(CHAIN_LEN - 1);
    assign last_pat = pat_cnt_q == PW'(PATTERN_CNT - 1);
    assign po_vec   = {cut_fz_L, cut_lclk, cut_read_a, cut_test_out, scan_out};

    // State register; reset overrides any coincident start
    always_ff @(posedge clock) state_q <= reset ? IDLE : state_d;

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: state_d = start ? RST_CUT : state_q;
            RST_CUT:    state_d = SHIFT;
            SHIFT:      state_d = last_bit ? CAPTURE : SHIFT;
            CAPTURE:    state_d = last_pat ? UNLOAD : SHIFT;
            UNLOAD:     state_d = last_bit ? DONE : UNLOAD;
            default:    state_d = IDLE;
        endcase
    end

    // Outputs and datapath controls decoded from the current state
    always_comb begin
        busy     = state_q inside {RST_CUT, SHIFT, CAPTURE, UNLOAD};
        done     = state_q == DONE;
        cut_rst  = state_q == RST_CUT;
        scan_en  = state_q inside {SHIFT, UNLOAD};
        scan_in  = (state_q == SHIFT) & prpg[0];
        {cut_s, cut_dv, cut_l_in, cut_test_in} = (state_q inside {SHIFT, CAPTURE, UNLOAD}) ? prpg[5:1] : '0;
        prpg_en  = state_q inside {SHIFT, CAPTURE};
`ifdef BIST_PO_COMPACT_EN
        misr_en  = state_q inside {SHIFT, CAPTURE, UNLOAD};
`else
        misr_en  = state_q inside {SHIFT, UNLOAD};
`endif
        misr_in  = {{(LFSR_W - PO_W){1'b0}}, (state_q == CAPTURE) ? po_vec : {{(PO_W - 1){1'b0}}, scan_out}};
        // MISR holds its final value through DONE and is only reloaded when RST_CUT ends
        sig_vis  = state_q inside {DONE, RST_CUT};
        signature = sig_vis ? misr : '0;
        pass     = sig_vis && (misr == GOLDEN_SIG);
    end

    // Bit counter spans one shift/unload pass; pattern counter counts captures
    always_comb begin
        bit_cnt_d = (state_q inside {SHIFT, UNLOAD}) ? (last_bit ? '0 : bit_cnt_q + CW'(1)) : '0;
        pat_cnt_d = cut_rst ? '0 : (state_q == CAPTURE) ? pat_cnt_q + PW'(1) : pat_cnt_q;
    end

    // Counter registers
    always_ff @(posedge clock) begin
        if (reset) begin
            bit_cnt_q <= '0;
            pat_cnt_q <= '0;
        end else begin
            bit_cnt_q <= bit_cnt_d;
            pat_cnt_q <= pat_cnt_d;
        end
    end

    bist_lfsr16 #(.RESET_VAL(LFSR_SEED)) u_prpg (
        .clock   (clock),
        .reset   (reset),
        .load_i  (cut_rst),
        .en_i    (prpg_en),
        .seed_i  (LFSR_SEED),
        .in_i    ('0),
        .state_o (prpg)
    );

    bist_lfsr16 #(.RESET_VAL('0)) u_misr (
        .clock   (clock),
        .reset   (reset),
        .load_i  (cut_rst),
        .en_i    (misr_en),
        .seed_i  ('0),
        .in_i    (misr_in),
        .state_o (misr)
    );

endmodule

// File: tb/tb_bist_scan_ctrl.sv
// tb_bist_scan_ctrl: directed self-checking bench for bist_scan_ctrl with a behavioural CUT
module tb_bist_scan_ctrl;

    localparam int          CL   = 12;
    localparam int          PC   = 64;
    localparam logic [15:0] SEED = 16'hACE1;
    localparam int          LAT  = 1 + PC * (CL + 1) + CL;

    function automatic logic [15:0] step16(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    function automatic logic [CL-1:0] cap12(input logic [CL-1:0] c, input logic [4:0] p);
        logic [CL-1:0] r;
        for (int i = 0; i < CL; i++) r[i] = c[i] ^ c[(i + 1) % CL] ^ p[i % 5];
        return r;
    endfunction

    // Reference session: PRPG, behavioural CUT and MISR stepped cycle by cycle
    function automatic logic [15:0] ref_sig(input logic stuck, input logic lclk);
        logic [15:0] prpg, misr;
        logic [CL-1:0] ch;
        logic [4:0] pi;
        logic so;
        prpg = SEED;
        misr = '0;
        ch = '0;
        for (int k = 0; k < PC; k++) begin
            for (int s = 0; s < CL; s++) begin
                so = stuck ? 1'b0 : ch[CL-1];
                misr = step16(misr) ^ {15'b0, so};
                ch = {ch[CL-2:0], prpg[0]};
                prpg = step16(prpg);
            end
            pi = prpg[5:1];
            so = stuck ? 1'b0 : ch[CL-1];
`ifdef BIST_PO_COMPACT_EN
            misr = step16(misr) ^ {6'b0, ~ch[0], lclk, ch[4:0] ^ pi, ch[1] ^ ch[0], pi[4], so};
`else
            if (lclk && so) misr = misr;
`endif
            ch = cap12(ch, pi);
            prpg = step16(prpg);
        end
        for (int s = 0; s < CL; s++) begin
            so = stuck ? 1'b0 : ch[CL-1];
            misr = step16(misr) ^ {15'b0, so};
            ch = {ch[CL-2:0], 1'b0};
        end
        return misr;
    endfunction

    localparam logic [15:0] SIG_GOOD  = ref_sig(1'b0, 1'b0);
    localparam logic [15:0] SIG_STUCK = ref_sig(1'b1, 1'b0);
    localparam logic [15:0] SIG_LCLK  = ref_sig(1'b0, 1'b1);

    logic clock = 1'b0;
    logic reset, start, s_start, stuck, lclk_en;
    logic busy, done, pass, cut_rst, scan_en, scan_in, cut_s, cut_dv, cut_l_in;
    logic [15:0] signature;
    logic [1:0] cut_test_in, cut_test_out;
    logic scan_out, cut_fz_L, cut_lclk;
    logic [4:0] cut_read_a, pi_v;
    logic [CL-1:0] chain = '0;
    logic s_busy, s_done, s_pass, s_cut_rst, s_scan_en, s_scan_in, s_cut_s, s_cut_dv, s_cut_l_in;
    logic [15:0] s_signature;
    logic [1:0] s_cut_test_in;
    int checks = 0;
    int fails = 0;

    always #5 clock = ~clock;

    bist_scan_ctrl #(.GOLDEN_SIG(SIG_GOOD)) dut (
        .clock(clock), .reset(reset), .start(start), .busy(busy), .done(done), .pass(pass),
        .signature(signature), .cut_rst(cut_rst), .scan_en(scan_en), .scan_in(scan_in),
        .cut_s(cut_s), .cut_dv(cut_dv), .cut_l_in(cut_l_in), .cut_test_in(cut_test_in),
        .scan_out(scan_out), .cut_fz_L(cut_fz_L), .cut_lclk(cut_lclk),
        .cut_read_a(cut_read_a), .cut_test_out(cut_test_out)
    );

    bist_scan_ctrl #(.CHAIN_LEN(4), .PATTERN_CNT(2)) dut_s (
        .clock(clock), .reset(reset), .start(s_start), .busy(s_busy), .done(s_done), .pass(s_pass),
        .signature(s_signature), .cut_rst(s_cut_rst), .scan_en(s_scan_en), .scan_in(s_scan_in),
        .cut_s(s_cut_s), .cut_dv(s_cut_dv), .cut_l_in(s_cut_l_in), .cut_test_in(s_cut_test_in),
        .scan_out(1'b0), .cut_fz_L(1'b0), .cut_lclk(1'b0),
        .cut_read_a(5'b0), .cut_test_out(2'b0)
    );

    assign pi_v         = {cut_s, cut_dv, cut_l_in, cut_test_in};
    assign scan_out     = stuck ? 1'b0 : chain[CL-1];
    assign cut_fz_L     = ~chain[0];
    assign cut_lclk     = lclk_en & busy & ~scan_en & ~cut_rst;
    assign cut_read_a   = chain[4:0] ^ pi_v;
    assign cut_test_out = {chain[1] ^ chain[0], pi_v[4]};

    always @(posedge clock) begin
        if (cut_rst) chain <= '0;
        else if (scan_en) chain <= {chain[CL-2:0], scan_in};
        else if (busy) chain <= cap12(chain, pi_v);
    end

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic run_big(output int n);
        @(negedge clock);
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (done !== 1'b1 && n < 2000) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b1;
        s_start = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        start = 1'b0;
        s_start = 1'b0;
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done got %b exp 0", done); end
        checks++; if (pass !== 1'b0) begin fails++; $display("FAIL reset_pass got %b exp 0", pass); end
        checks++; if (signature !== 16'h0) begin fails++; $display("FAIL reset_sig got %h exp 0000", signature); end
        checks++; if ({cut_rst, scan_en, scan_in} !== 3'b0) begin fails++; $display("FAIL reset_scan got %b exp 000", {cut_rst, scan_en, scan_in}); end
        checks++; if (pi_v !== 5'b0) begin fails++; $display("FAIL reset_pi got %b exp 00000", pi_v); end
        tick();
        checks++; if (busy !== 1'b0 || s_busy !== 1'b0) begin fails++; $display("FAIL reset_start_dropped got %b%b exp 00", busy, s_busy); end
    endtask

    task automatic test_timing();
        logic exp_en;
        @(negedge clock);
        s_start = 1'b1;
        tick();
        s_start = 1'b0;
        checks++; if ({s_cut_rst, s_busy, s_scan_en} !== 3'b110) begin fails++; $display("FAIL timing_rstcut got %b exp 110", {s_cut_rst, s_busy, s_scan_en}); end
        for (int k = 1; k <= 15; k++) begin
            tick();
            exp_en = (k <= 4) || (k >= 6 && k <= 9) || (k >= 11 && k <= 14);
            checks++; if (s_scan_en !== exp_en) begin fails++; $display("FAIL timing_scan_en cyc %0d got %b exp %b", k, s_scan_en, exp_en); end
            checks++; if (s_done !== (k == 15)) begin fails++; $display("FAIL timing_done cyc %0d got %b exp %b", k, s_done, k == 15); end
        end
        checks++; if (s_signature !== 16'h0 || s_pass !== 1'b1) begin fails++; $display("FAIL timing_result got %h/%b exp 0000/1", s_signature, s_pass); end
    endtask

    task automatic test_golden();
        int n;
        run_big(n);
        checks++; if (n !== LAT) begin fails++; $display("FAIL golden_latency got %0d exp %0d", n, LAT); end
        checks++; if (signature !== SIG_GOOD) begin fails++; $display("FAIL golden_sig got %h exp %h", signature, SIG_GOOD); end
        checks++; if (pass !== 1'b1 || busy !== 1'b0) begin fails++; $display("FAIL golden_pass got %b/%b exp 1/0", pass, busy); end
        repeat (5) tick();
        checks++; if (done !== 1'b1 || signature !== SIG_GOOD) begin fails++; $display("FAIL golden_hold got %b/%h exp 1/%h", done, signature, SIG_GOOD); end
    endtask

    task automatic test_back_to_back();
        int n;
        @(negedge clock);
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++; if ({done, busy, cut_rst} !== 3'b011) begin fails++; $display("FAIL restart_from_done got %b exp 011", {done, busy, cut_rst}); end
        n = 0;
        while (done !== 1'b1 && n < 2000) begin
            if (n == 100 || n == 500 || n == LAT - 2) start = 1'b1;
            tick();
            start = 1'b0;
            n++;
        end
        checks++; if (n !== LAT) begin fails++; $display("FAIL busy_start_latency got %0d exp %0d", n, LAT); end
        checks++; if (signature !== SIG_GOOD) begin fails++; $display("FAIL busy_start_sig got %h exp %h", signature, SIG_GOOD); end
    endtask

    task automatic test_stuck();
        int n;
        stuck = 1'b1;
        run_big(n);
        stuck = 1'b0;
        checks++; if (n !== LAT) begin fails++; $display("FAIL stuck_latency got %0d exp %0d", n, LAT); end
        checks++; if (signature !== SIG_STUCK) begin fails++; $display("FAIL stuck_sig got %h exp %h", signature, SIG_STUCK); end
        checks++; if (pass !== (SIG_STUCK == SIG_GOOD)) begin fails++; $display("FAIL stuck_pass got %b exp %b", pass, SIG_STUCK == SIG_GOOD); end
    endtask

    task automatic test_lclk();
        int n;
        lclk_en = 1'b1;
        run_big(n);
        lclk_en = 1'b0;
        checks++; if (signature !== SIG_LCLK) begin fails++; $display("FAIL lclk_sig got %h exp %h", signature, SIG_LCLK); end
`ifdef BIST_PO_COMPACT_EN
        checks++; if (signature === SIG_GOOD) begin fails++; $display("FAIL lclk_effect got %h exp differ from %h", signature, SIG_GOOD); end
`else
        checks++; if (signature !== SIG_GOOD) begin fails++; $display("FAIL lclk_effect got %h exp %h", signature, SIG_GOOD); end
`endif
    endtask

    task automatic test_reset_mid();
        int n;
        @(negedge clock);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (32) tick();
        checks++; if ({busy, scan_en} !== 2'b11) begin fails++; $display("FAIL mid_in_shift got %b exp 11", {busy, scan_en}); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if ({busy, scan_en, done, pass} !== 4'b0) begin fails++; $display("FAIL mid_abort got %b exp 0000", {busy, scan_en, done, pass}); end
        checks++; if (signature !== 16'h0 || pi_v !== 5'b0) begin fails++; $display("FAIL mid_sig got %h/%b exp 0000/00000", signature, pi_v); end
        run_big(n);
        checks++; if (n !== LAT) begin fails++; $display("FAIL mid_rerun_latency got %0d exp %0d", n, LAT); end
        checks++; if (signature !== SIG_GOOD || pass !== 1'b1) begin fails++; $display("FAIL mid_rerun got %h/%b exp %h/1", signature, pass, SIG_GOOD); end
    endtask

    initial begin
        stuck = 1'b0;
        lclk_en = 1'b0;
        test_reset();
        test_timing();
        test_golden();
        test_back_to_back();
        test_stuck();
        test_lclk();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
